ps2_cmd_sequencer: RTL
======================

// Module: ps2_cmd_sequencer
// PURPOSE
//  Host-to-keyboard command controller for the PS/2 link. Accepts a command (opcode + optional argument),
//  drives the PS/2 byte transmitter one byte at a time, and waits for the keyboard's response on the
//  receive path (scanDone/scanCode from the PS/2 receiver). Consumes response bytes and forwards all
//  other scan codes to the decoder. Retries, times out and reports completion/error.
// PARAMETERS
//  TIMEOUT_CYCLES  2_000_000  max clk cycles per phase (tx completion or response wait)
//  MAX_RETRY       3          resends allowed per command on 0xFE (only with PS2_CMD_RETRY_EN)
// PORTS
//  clk          in   1  system clock; single clock domain
//  reset        in   1  synchronous, active-high reset
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
//  cmd_op       in   8  opcode byte, e.g. 8'hED (set LEDs)
//  cmd_has_arg  in   1  1 = send cmd_arg after opcode is ACKed
//  cmd_arg      in   8  argument byte
//  tx_start     out  1  one-cycle pulse: transmitter sends tx_byte
//  tx_byte      out  8  byte to send; stable from tx_start until tx_done
//  tx_done      in   1  one-cycle pulse: byte sent, line ACKed by device
//  tx_err       in   1  one-cycle pulse: transmit failed (no line ACK)
//  rx_done      in   1  scanDone pulse from receiver
//  rx_code      in   8  scanCode, valid with rx_done
//  fwd_valid    out  1  one-cycle pulse: forwarded scan code for decoder
//  fwd_code     out  8  forwarded code, valid with fwd_valid
//  done         out  1  one-cycle pulse: command completed
//  error        out  1  one-cycle pulse: command aborted
//  err_code     out  2  01 timeout, 10 resend limit, 11 device fail (0xFC) or tx_err; held until next error
// BEHAVIOUR
//  Reset values: cmd_ready=1, tx_start=0, tx_byte=0, fwd_valid=0, fwd_code=0, done=0, error=0,
//  err_code=00. All outputs registered except cmd_ready (= state==IDLE).
//  States: IDLE -> TX_OP -> ACK_OP -> [TX_ARG -> ACK_ARG] -> IDLE.
//  - IDLE: accept at edge N; latch op/arg/has_arg; tx_start=1, tx_byte=op at N+1; enter TX_OP.
//  - TX_OP/TX_ARG: wait for tx_done -> ACK_x. tx_err -> error, code 11, IDLE.
//  - ACK_x on rx_done: 8'hFA -> ACK_OP w/ has_arg: tx_start + tx_byte=arg next cycle, TX_ARG;
//    else done pulse next cycle, IDLE. 8'hFE -> resend same byte (retry path). 8'hFC -> error 11.
//    Any other code: forwarded, state unchanged.
//  - Responses 8'hFA/8'hFE/8'hFC consumed (never forwarded) only in ACK_x states; in every other state
//    all codes forwarded. fwd_valid asserted cycle after rx_done, fwd_code=rx_code.
//  - Timeout counter cleared on entering each TX_x/ACK_x state; at TIMEOUT_CYCLES-1 with no event
//    -> error, code 01, IDLE.
//  - Simultaneous: rx_done or tx_done on the expiry cycle wins over timeout. cmd_valid outside IDLE
//    ignored (requester holds it). done and error never assert together.
//  - Retry counter cleared on command accept, shared across both bytes of a command.
//  - Reset mid-command: IDLE on next edge, command dropped, no done/error, tx_start low.
// CONFIGURATION
//  PS2_CMD_RETRY_EN defined: 8'hFE with retry_cnt<MAX_RETRY -> retry_cnt++, tx_start re-issued with
//  same tx_byte next cycle, back to TX_x; at MAX_RETRY -> error, code 10.
//  Undefined: 8'hFE -> error, code 10, immediately; no retry counter present.
// STRUCTURE
//  ps2_pkg: state encoding, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_FAIL=8'hFC, ERR_TIMEOUT/ERR_RESEND/ERR_DEVICE.
//  Sub-module ps2_timeout_counter (clr, expired; width from TIMEOUT_CYCLES); FSM and rx filter stay top.
// TESTING
//  1 cmd ED/has_arg/07: tx_done, rx FA, tx_done, rx FA -> tx_byte ED then 07, one done, no fwd.
//  2 cmd F4 no arg; rx 1C during ACK_OP then FA -> fwd_code=1C pulse, then done; FA not forwarded.
//  3 RETRY_EN, MAX_RETRY=3: four FE replies -> three resends of ED, then error, err_code=10.
//  4 no rx after tx_done (TIMEOUT_CYCLES=100) -> error, err_code=01 exactly 100 cycles after ACK_OP entry.
//  5 IDLE, rx FA -> forwarded; reset asserted in ACK_ARG -> cmd_ready=1 next cycle, no done/error.
//  6 tx_err in TX_OP -> error, code 11; rx FC in ACK_ARG -> error, code 11.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 host command sequencer.
// State encoding, device response bytes and error codes.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_OP,
      S_ACK_OP,
      S_TX_ARG,
      S_ACK_ARG
   } state_t;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_FAIL   = 8'hFC;

   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_RESEND  = 2'b10;
   localparam logic [1:0] ERR_DEVICE  = 2'b11;

   function automatic logic is_resp(input logic [7:0] c);
      return (c == PS2_ACK) || (c == PS2_RESEND) || (c == PS2_FAIL);
   endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Per-phase watchdog: counts cycles since the last clear and
// flags expiry on the TIMEOUT_CYCLES-th cycle, then holds.
module ps2_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic expired
);

   localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt;

   assign expired = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (!expired)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-to-keyboard command sequencer with response filtering.
// Define PS2_CMD_RETRY_EN to resend on 0xFE up to MAX_RETRY times.
module ps2_cmd_sequencer
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
`ifdef PS2_CMD_RETRY_EN
   , parameter int unsigned MAX_RETRY = 3
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_op,
   input  logic       cmd_has_arg,
   input  logic [7:0] cmd_arg,
   output logic       tx_start,
   output logic [7:0] tx_byte,
   input  logic       tx_done,
   input  logic       tx_err,
   input  logic       rx_done,
   input  logic [7:0] rx_code,
   output logic       fwd_valid,
   output logic [7:0] fwd_code,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);

   state_t     state, state_n;
   logic       has_arg;
   logic [7:0] arg;
   logic       latch;
   logic       expired;
   logic       tmo_clr;
   logic       in_ack;

   logic       tx_start_n, fwd_valid_n, done_n, error_n;
   logic [7:0] tx_byte_n, fwd_code_n;
   logic [1:0] err_code_n;

`ifdef PS2_CMD_RETRY_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0] retry_cnt;
   logic          retry_inc;
   logic          retry_ok;

   assign retry_ok = (retry_cnt < RW'(MAX_RETRY));

   always_ff @(posedge clk) begin
      if (reset || latch)
         retry_cnt <= '0;
      else if (retry_inc)
         retry_cnt <= retry_cnt + 1'b1;
   end
`endif

   assign cmd_ready = (state == S_IDLE);
   assign in_ack    = (state == S_ACK_OP) || (state == S_ACK_ARG);
   // Every entry into a waiting phase (including a resend) restarts the watchdog.
   assign tmo_clr   = (state == S_IDLE) || (state_n != state);

   ps2_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .reset  (reset),
      .clr    (tmo_clr),
      .expired(expired)
   );

   always_comb begin
      state_n     = state;
      latch       = 1'b0;
      tx_start_n  = 1'b0;
      tx_byte_n   = tx_byte;
      fwd_valid_n = 1'b0;
      fwd_code_n  = fwd_code;
      done_n      = 1'b0;
      error_n     = 1'b0;
      err_code_n  = err_code;
`ifdef PS2_CMD_RETRY_EN
      retry_inc   = 1'b0;
`endif

      if (rx_done && !(in_ack && is_resp(rx_code))) begin
         fwd_valid_n = 1'b1;
         fwd_code_n  = rx_code;
      end

      unique case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               latch      = 1'b1;
               tx_start_n = 1'b1;
               tx_byte_n  = cmd_op;
               state_n    = S_TX_OP;
            end
         end
         S_TX_OP, S_TX_ARG: begin
            if (tx_done) begin
               state_n = (state == S_TX_OP) ? S_ACK_OP : S_ACK_ARG;
            end else if (tx_err) begin
               error_n    = 1'b1;
               err_code_n = ERR_DEVICE;
               state_n    = S_IDLE;
            end else if (expired) begin
               error_n    = 1'b1;
               err_code_n = ERR_TIMEOUT;
               state_n    = S_IDLE;
            end
         end
         S_ACK_OP, S_ACK_ARG: begin
            if (rx_done) begin
               if (rx_code == PS2_ACK) begin
                  if (state == S_ACK_OP && has_arg) begin
                     tx_start_n = 1'b1;
                     tx_byte_n  = arg;
                     state_n    = S_TX_ARG;
                  end else begin
                     done_n  = 1'b1;
                     state_n = S_IDLE;
                  end
               end else if (rx_code == PS2_RESEND) begin
`ifdef PS2_CMD_RETRY_EN
                  if (retry_ok) begin
                     retry_inc  = 1'b1;
                     tx_start_n = 1'b1;
                     state_n    = (state == S_ACK_OP) ? S_TX_OP : S_TX_ARG;
                  end else begin
                     error_n    = 1'b1;
                     err_code_n = ERR_RESEND;
                     state_n    = S_IDLE;
                  end
`else
                  error_n    = 1'b1;
                  err_code_n = ERR_RESEND;
                  state_n    = S_IDLE;
`endif
               end else if (rx_code == PS2_FAIL) begin
                  error_n    = 1'b1;
                  err_code_n = ERR_DEVICE;
                  state_n    = S_IDLE;
               end
            end else if (expired) begin
               error_n    = 1'b1;
               err_code_n = ERR_TIMEOUT;
               state_n    = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         has_arg   <= 1'b0;
         arg       <= '0;
         tx_start  <= 1'b0;
         tx_byte   <= '0;
         fwd_valid <= 1'b0;
         fwd_code  <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_code  <= '0;
      end else begin
         state     <= state_n;
         tx_start  <= tx_start_n;
         tx_byte   <= tx_byte_n;
         fwd_valid <= fwd_valid_n;
         fwd_code  <= fwd_code_n;
         done      <= done_n;
         error     <= error_n;
         err_code  <= err_code_n;
         if (latch) begin
            has_arg <= cmd_has_arg;
            arg     <= cmd_arg;
         end
      end
   end

endmodule
